// File: rtl/flash_ssram_seq_pkg.sv
// Shared types and constants for the flash/SSRAM bus sequencer.
// Optional build macro: FLASH_SSRAM_SEQ_FIXED_PRIO_EN (fixed priority instead of round-robin).
package flash_ssram_seq_pkg;

    localparam int unsigned NUM_REQ = 2;

    localparam logic TGT_FLASH = 1'b0;
    localparam logic TGT_SSRAM = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StFSetup,
        StFAccess,
        StFHold,
        StSCmd,
        StSWait,
        StTurn
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flash_ssram_rr_arb.sv
// Two-requester grant logic: round-robin on rr_last_i, or fixed priority to requester 0
// when FLASH_SSRAM_SEQ_FIXED_PRIO_EN is defined (rr_last_i then does not exist).
module flash_ssram_rr_arb
    import flash_ssram_seq_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
`ifndef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
    input  logic               rr_last_i,
`endif
    output logic               grant_vld_o,
    output logic               grant_idx_o
);

    always_comb begin
        grant_vld_o = |req_i;
        grant_idx_o = 1'b0;
        if (req_i == 2'b11) begin
`ifdef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
            grant_idx_o = 1'b0;
`else
            grant_idx_o = ~rr_last_i;
`endif
        end else if (req_i[1]) begin
            grant_idx_o = 1'b1;
        end
    end

endmodule

// File: rtl/flash_ssram_bus_sequencer.sv
// Shares one flash/SSRAM tristate bus between two requesters with timed strobes.
// Optional build macro: FLASH_SSRAM_SEQ_FIXED_PRIO_EN (requester 0 always wins a tie).
module flash_ssram_bus_sequencer
    import flash_ssram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FLASH_SETUP  = 2,
    parameter int unsigned FLASH_WAIT   = 8,
    parameter int unsigned FLASH_HOLD   = 1,
    parameter int unsigned SSRAM_RD_LAT = 2,
    parameter int unsigned TURNAROUND   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_tgt,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [2*ADDR_W-1:0]       req_addr,
    input  logic [2*DATA_W-1:0]       req_wdata,
    input  logic [2*(DATA_W/8)-1:0]   req_be,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         bus_a,
    output logic [DATA_W-1:0]         bus_d_out,
    output logic                      bus_d_oe,
    input  logic [DATA_W-1:0]         bus_d_in,
    output logic                      flash_cs_n,
    output logic                      flash_oe_n,
    output logic                      flash_wr_n,
    output logic                      ssram_ce_n,
    output logic                      ssram_adsc_n,
    output logic                      ssram_oe_n,
    output logic                      ssram_bwe_n,
    output logic [DATA_W/8-1:0]       ssram_bw_n
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned MAX_T = max_u(max_u(max_u(FLASH_SETUP, FLASH_WAIT),
                                                max_u(FLASH_HOLD, SSRAM_RD_LAT)), TURNAROUND);
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters run down to zero; these are the load values on state entry.
    localparam cnt_t SETUP_LD = cnt_t'(FLASH_SETUP - 1);
    localparam cnt_t WAIT_LD  = cnt_t'(FLASH_WAIT - 1);
    localparam cnt_t HOLD_LD  = (FLASH_HOLD > 0) ? cnt_t'(FLASH_HOLD - 1) : '0;
    localparam cnt_t RDLAT_LD = cnt_t'(SSRAM_RD_LAT - 1);
    localparam cnt_t TURN_LD  = (TURNAROUND > 0) ? cnt_t'(TURNAROUND - 1) : '0;

    seq_state_e         state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic               we_q, we_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
`ifndef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
    logic               rr_last_q, rr_last_d;
`endif

    logic               grant_vld;
    logic               grant_idx;
    logic               xfer_end;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;

    flash_ssram_rr_arb u_arb (
        .req_i       (req),
`ifndef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
        .rr_last_i   (rr_last_q),
`endif
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx)
    );

    assign sel_addr  = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign sel_be    = grant_idx ? req_be[2*BE_W-1:BE_W]        : req_be[BE_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        xfer_end  = 1'b0;
`ifndef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
        rr_last_d = rr_last_q;
`endif

        unique case (state_q)
            StIdle: begin
                // A done cycle never arbitrates: the finishing requester still holds req.
                if (grant_vld && (done_q == '0)) begin
                    grant_d = grant_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    we_d    = req_we[grant_idx];
`ifndef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
                    rr_last_d = grant_idx;
`endif
                    if (req_tgt[grant_idx] == TGT_FLASH) begin
                        state_d = StFSetup;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = StSCmd;
                    end
                end
            end
            StFSetup: begin
                if (cnt_q == '0) begin
                    state_d = StFAccess;
                    cnt_d   = WAIT_LD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StFAccess: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = bus_d_in;
                    end
                    if (FLASH_HOLD > 0) begin
                        state_d = StFHold;
                        cnt_d   = HOLD_LD;
                    end else begin
                        xfer_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StFHold: begin
                if (cnt_q == '0) begin
                    xfer_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StSCmd: begin
                if (we_q) begin
                    xfer_end = 1'b1;
                end else begin
                    state_d = StSWait;
                    cnt_d   = RDLAT_LD;
                end
            end
            StSWait: begin
                if (cnt_q == '0) begin
                    rdata_d  = bus_d_in;
                    xfer_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer_end) begin
            done_d = grant_q ? 2'b10 : 2'b01;
            if (!we_q && (TURNAROUND > 0)) begin
                state_d = StTurn;
                cnt_d   = TURN_LD;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Pin decode straight from state so an async reset drops every strobe at once.
    always_comb begin
        bus_a        = '0;
        bus_d_out    = '0;
        bus_d_oe     = 1'b0;
        flash_cs_n   = 1'b1;
        flash_oe_n   = 1'b1;
        flash_wr_n   = 1'b1;
        ssram_ce_n   = 1'b1;
        ssram_adsc_n = 1'b1;
        ssram_oe_n   = 1'b1;
        ssram_bwe_n  = 1'b1;
        ssram_bw_n   = '1;

        unique case (state_q)
            StFSetup, StFHold: begin
                bus_a      = addr_q;
                flash_cs_n = 1'b0;
                bus_d_oe   = we_q;
            end
            StFAccess: begin
                bus_a      = addr_q;
                flash_cs_n = 1'b0;
                bus_d_oe   = we_q;
                flash_oe_n = we_q;
                flash_wr_n = ~we_q;
            end
            StSCmd: begin
                bus_a        = addr_q;
                ssram_ce_n   = 1'b0;
                ssram_adsc_n = 1'b0;
                if (we_q) begin
                    ssram_bwe_n = 1'b0;
                    ssram_bw_n  = ~be_q;
                    bus_d_oe    = 1'b1;
                end
            end
            StSWait: ssram_oe_n = 1'b0;
            default: ;
        endcase

        if (bus_d_oe) begin
            bus_d_out = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

`ifndef FLASH_SSRAM_SEQ_FIXED_PRIO_EN
    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: doc/flash_ssram_bus_sequencer.md
Name: flash_ssram_bus_sequencer

Overview:
- Shares the board's single flash/SSRAM tristate bus (common address and data pins) between two requesters, e.g. CPU data master and a DMA.
- Arbitrates round-robin and generates timed flash strobes (setup/wait/hold) or synchronous SSRAM cycles (ADSC/BWE/OE).
- Returns read data with a one-cycle done pulse.
- Sits between the system interconnect and the top-level flash/SSRAM pins, replacing the vendor tristate bridge.

Parameters:
- ADDR_W, 24, shared address bus width.
- DATA_W, 32, shared data bus width; byte enables are DATA_W/8.
- FLASH_SETUP, 2, cycles address and CS are valid before OE/WR assert (>=1).
- FLASH_WAIT, 8, cycles OE/WR stay asserted (>=1).
- FLASH_HOLD, 1, cycles address, CS and write data are held after OE/WR deassert (>=0).
- SSRAM_RD_LAT, 2, cycles from ADSC to valid SSRAM read data (1..3).
- TURNAROUND, 1, idle bus cycles inserted after any read before the next transaction (>=0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester request; held until done.
- req_tgt  in  2  per-requester target: 0=flash, 1=SSRAM.
- req_we  in  2  per-requester direction: 1=write.
- req_addr  in  2*ADDR_W  requester n at [n*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  write data, packed the same way.
- req_be  in  2*DATA_W/8  byte enables, active high.
- done  out  2  one-cycle completion pulse per requester.
- rdata  out  DATA_W  read data, valid only in a done cycle for a read.
- bus_a  out  ADDR_W  shared address pins.
- bus_d_out  out  DATA_W  data driven to pins.
- bus_d_oe  out  1  data pin output enable.
- bus_d_in  in  DATA_W  data sampled from pins.
- flash_cs_n, flash_oe_n, flash_wr_n  out  1 each  flash strobes.
- ssram_ce_n, ssram_adsc_n, ssram_oe_n, ssram_bwe_n  out  1 each  SSRAM controls.
- ssram_bw_n  out  DATA_W/8  SSRAM byte write enables.

Behaviour:
- Reset (async): state IDLE; all _n outputs 1; bus_d_oe=0; bus_a=0; bus_d_out=0; done=0; rdata=0; rr_last=1, so requester 0 wins first.
- Reset mid-transaction aborts immediately: strobes and bus_d_oe drop in the same instant; no done pulse.
- FSM states: IDLE, F_SETUP, F_ACCESS, F_HOLD, S_CMD, S_WAIT, TURN.
- IDLE arbitration:
  - If both request, grant the requester not equal to rr_last; a single request wins outright.
  - Latch grant, addr, wdata, be, tgt and we into registers.
  - Set rr_last=grant and leave IDLE on the next edge.
  - No request: stay in IDLE.
- Flash path:
  - F_SETUP (FLASH_SETUP cycles): bus_a and flash_cs_n=0 driven; for a write, bus_d_oe=1 with data driven.
  - F_ACCESS (FLASH_WAIT cycles): flash_oe_n=0 on a read, flash_wr_n=0 on a write.
  - Read data is captured from bus_d_in on the last F_ACCESS cycle.
  - F_HOLD (FLASH_HOLD cycles): CS, address and write data held; OE/WR deasserted.
  - FLASH_HOLD=0 skips F_HOLD.
- SSRAM path:
  - S_CMD (1 cycle): ssram_ce_n=0, ssram_adsc_n=0, bus_a driven.
  - Write: ssram_bwe_n=0, ssram_bw_n=~be, bus_d_oe=1; done asserts in the following cycle and the FSM goes to IDLE.
  - Read: S_WAIT holds ssram_oe_n=0 for SSRAM_RD_LAT cycles, then bus_d_in is captured.
- Completion:
  - done[grant] pulses exactly one cycle after the last bus-active cycle, with rdata registered.
  - Latency from grant edge: flash = FLASH_SETUP+FLASH_WAIT+FLASH_HOLD+1; SSRAM write = 2; SSRAM read = SSRAM_RD_LAT+2.
- After a read, go to TURN for TURNAROUND cycles (all idle, bus_d_oe=0) before IDLE; writes go straight to IDLE.
- The granted requester may raise a new req in its done cycle. It is considered in the next IDLE, still subject to round-robin.
- Requester inputs are ignored while a transaction is in flight. A req dropped mid-transaction does not abort it; done still pulses.
- bus_d_oe is never 1 in the same cycle as flash_oe_n=0 or ssram_oe_n=0.
- Cycle counters are sized $clog2(max timing parameter + 1).

Optional Feature:
- Macro FLASH_SSRAM_SEQ_FIXED_PRIO_EN.
- Defined: requester 0 always wins a simultaneous request; rr_last is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package flash_ssram_seq_pkg: state enum, TGT_FLASH/TGT_SSRAM constants, requester count (2).
- One natural sub-module, flash_ssram_rr_arb: two-input round-robin/fixed-priority grant logic.

Test Plan:
- Flash read, defaults, req[0], addr 0x000100: flash_oe_n low exactly 8 cycles, starting 2 cycles after CS. done[0] pulses at grant+12 with rdata = bus model value 0xA5A5_0001.
- SSRAM write, req[1], be=4'b0011, wdata 0xDEADBEEF: one ADSC cycle with ssram_bw_n=4'b1100 and bus_d_oe=1. done[1] pulses at grant+2.
- Both requesters hold back-to-back SSRAM reads: grants alternate 0,1,0,1. One TURN cycle with bus_d_oe=0 between them; no done overlap.
- With FLASH_SSRAM_SEQ_FIXED_PRIO_EN and both requesting continuously: only requester 0 completes.
- Reset asserted in the middle of F_ACCESS on a flash write: flash_wr_n=1, flash_cs_n=1 and bus_d_oe=0 immediately with no done. After release, a fresh request completes normally.
- SSRAM_RD_LAT=3, FLASH_HOLD=0 build: SSRAM read done at grant+5; flash read done at grant+11.
